// File: rtl/muldiv_unit_pkg.sv
// Shared op codes, FSM encoding and op-decode helpers for the multiply/divide unit.
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MD_OP_MULT  = 3'd0,
    MD_OP_MULTU = 3'd1,
    MD_OP_DIV   = 3'd2,
    MD_OP_DIVU  = 3'd3,
    MD_OP_MTHI  = 3'd4,
    MD_OP_MTLO  = 3'd5,
    MD_OP_NOP   = 3'd6,
    MD_OP_NOP7  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

  function automatic logic is_div_op(md_op_e op);
    return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
  endfunction

  function automatic logic is_mul_op(md_op_e op);
    return (op == MD_OP_MULT) || (op == MD_OP_MULTU);
  endfunction

  function automatic logic is_signed_op(md_op_e op);
    return (op == MD_OP_MULT) || (op == MD_OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Execute-stage handshake between the pipeline (master) and the multiply/divide unit (slave).
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             annul;
  logic             stall;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, annul,
    input  stall, busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, annul,
    output stall, busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_iter_core.sv
// Radix-2 iterative datapath on magnitudes: restoring divide or shift-add multiply,
// plus the 0..WIDTH-1 iteration counter. acc ends as remainder/product-high, shreg as quotient/product-low.
module muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             mul_mode_in,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic             last,
  output logic [WIDTH-1:0] hi_part,
  output logic [WIDTH-1:0] lo_part
);
  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] opnd;
  logic             mul_mode;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] shreg_next;

  // A negative trial difference (borrow in the top bit) means the divisor did not fit.
  always_comb begin
    rem_shift  = {acc, shreg[WIDTH-1]};
    diff       = rem_shift - {1'b0, opnd};
    sum        = {1'b0, acc} + (shreg[0] ? {1'b0, opnd} : '0);
    acc_next   = acc;
    shreg_next = shreg;
    if (mul_mode) begin
      acc_next   = sum[WIDTH:1];
      shreg_next = {sum[0], shreg[WIDTH-1:1]};
    end else if (diff[WIDTH]) begin
      acc_next   = rem_shift[WIDTH-1:0];
      shreg_next = {shreg[WIDTH-2:0], 1'b0};
    end else begin
      acc_next   = diff[WIDTH-1:0];
      shreg_next = {shreg[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      acc      <= '0;
      shreg    <= '0;
      opnd     <= '0;
      mul_mode <= 1'b0;
    end else if (load) begin
      count    <= '0;
      acc      <= '0;
      shreg    <= a_mag;
      opnd     <= b_mag;
      mul_mode <= mul_mode_in;
    end else if (step) begin
      count    <= count + CW'(1);
      acc      <= acc_next;
      shreg    <= shreg_next;
    end
  end

  assign last    = (count == CW'(WIDTH - 1));
  assign hi_part = acc;
  assign lo_part = shreg;

endmodule

// File: rtl/muldiv_unit.sv
// Multiply/divide unit owning HI/LO: FSM, sign fix-up and start/stall/done handshake.
// Define MULDIV_ITER_MUL_EN to run MULT/MULTU through the iterative core instead of a combinational multiplier.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  muldiv_unit_if.slave   bus
);

  md_state_e        state;
  md_state_e        state_next;
  md_op_e           op;
  logic             is_div;
  logic             div_by_zero;
  logic             multi_op;
  logic             accept;
  logic             sgn_in;
  logic             core_load;
  logic             core_step;
  logic             core_last;
  logic             fix_write;
  logic             a_neg_q;
  logic             b_neg_q;
  logic             busy_q;
  logic             done_q;
  logic             dz_q;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] core_hi;
  logic [WIDTH-1:0] core_lo;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  assign op          = md_op_e'(bus.op);
  assign is_div      = is_div_op(op);
  assign div_by_zero = is_div && (bus.b == '0);
  assign accept      = bus.start && !bus.annul && (state == ST_IDLE);
  assign sgn_in      = is_signed_op(op);
  assign a_mag       = (sgn_in && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag       = (sgn_in && bus.b[WIDTH-1]) ? -bus.b : bus.b;

`ifdef MULDIV_ITER_MUL_EN
  logic is_mul;
  logic mul_q;
  logic [2*WIDTH-1:0] prod_fixed;

  assign is_mul   = is_mul_op(op);
  assign multi_op = (is_div || is_mul) && !div_by_zero;
`else
  logic [2*WIDTH-1:0] mul_x;
  logic [2*WIDTH-1:0] mul_y;
  logic [2*WIDTH-1:0] mul_p;

  // Extending to 2*WIDTH first lets one unsigned multiplier serve both MULT and MULTU.
  assign mul_x    = sgn_in ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a} : {{WIDTH{1'b0}}, bus.a};
  assign mul_y    = sgn_in ? {{WIDTH{bus.b[WIDTH-1]}}, bus.b} : {{WIDTH{1'b0}}, bus.b};
  assign mul_p    = mul_x * mul_y;
  assign multi_op = is_div && !div_by_zero;
`endif

  assign bus.stall    = busy_q || (accept && multi_op);
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk         (clk),
    .rst         (rst),
    .load        (core_load),
    .step        (core_step),
`ifdef MULDIV_ITER_MUL_EN
    .mul_mode_in (is_mul),
`else
    .mul_mode_in (1'b0),
`endif
    .a_mag       (a_mag),
    .b_mag       (b_mag),
    .last        (core_last),
    .hi_part     (core_hi),
    .lo_part     (core_lo)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // annul abandons RUN/FIX without touching HI/LO.
  always_comb begin
    state_next = state;
    core_load  = 1'b0;
    core_step  = 1'b0;
    fix_write  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept && multi_op) begin
          state_next = ST_RUN;
          core_load  = 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.annul) begin
          state_next = ST_IDLE;
        end else begin
          core_step = 1'b1;
          if (core_last) state_next = ST_FIX;
        end
      end
      ST_FIX: begin
        state_next = ST_IDLE;
        fix_write  = !bus.annul;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Quotient sign is the XOR of operand signs; remainder follows the dividend.
  always_comb begin
    fix_lo = (a_neg_q ^ b_neg_q) ? -core_lo : core_lo;
    fix_hi = a_neg_q ? -core_hi : core_hi;
`ifdef MULDIV_ITER_MUL_EN
    prod_fixed = (a_neg_q ^ b_neg_q) ? -{core_hi, core_lo} : {core_hi, core_lo};
    if (mul_q) {fix_hi, fix_lo} = prod_fixed;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
`ifdef MULDIV_ITER_MUL_EN
      mul_q   <= 1'b0;
`endif
    end else if (core_load) begin
      a_neg_q <= sgn_in && bus.a[WIDTH-1];
      b_neg_q <= sgn_in && bus.b[WIDTH-1];
`ifdef MULDIV_ITER_MUL_EN
      mul_q   <= is_mul;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      busy_q <= (state_next != ST_IDLE);
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      if (fix_write) begin
        hi_q   <= fix_hi;
        lo_q   <= fix_lo;
        done_q <= 1'b1;
      end else if (accept) begin
        case (op)
          MD_OP_MTHI: begin
            hi_q   <= bus.a;
            done_q <= 1'b1;
          end
          MD_OP_MTLO: begin
            lo_q   <= bus.a;
            done_q <= 1'b1;
          end
`ifndef MULDIV_ITER_MUL_EN
          MD_OP_MULT, MD_OP_MULTU: begin
            {hi_q, lo_q} <= mul_p;
            done_q       <= 1'b1;
          end
`endif
          MD_OP_DIV, MD_OP_DIVU: begin
            if (div_by_zero) begin
              done_q <= 1'b1;
              dz_q   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: an arithmetic reference model queues expected HI/LO and done cycles.
// Adapts to MULDIV_ITER_MUL_EN for the MULT/MULTU latency.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int W = 32;
`ifdef MULDIV_ITER_MUL_EN
  localparam bit ITER_MUL = 1'b1;
`else
  localparam bit ITER_MUL = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   free_cyc = 0;
  logic [W-1:0] model_hi;
  logic [W-1:0] model_lo;
  exp_t scoreboard[$];
  exp_t mon_e;

  muldiv_unit_if #(.WIDTH(W)) bus ();
  muldiv_unit_if #(.WIDTH(8)) bus8 ();

  muldiv_unit #(.WIDTH(W)) dut  (.clk(clk), .rst(rst), .bus(bus));
  muldiv_unit #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
  endtask

  // Reference behaviour in plain 64-bit arithmetic; SV / and % truncate toward zero.
  function automatic void refModel(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   inout logic [W-1:0] hi, inout logic [W-1:0] lo, output logic dz);
    longint          sa, sbv, sq, sr;
    longint unsigned ua, ub, uq, ur;
    dz = 1'b0;
    sa = longint'($signed(a));
    sbv = longint'($signed(b));
    ua = a;
    ub = b;
    case (op)
      3'd0: begin sq = sa * sbv; {hi, lo} = sq; end
      3'd1: begin uq = ua * ub; {hi, lo} = uq; end
      3'd2: if (b == '0) dz = 1'b1;
            else begin sq = sa / sbv; sr = sa % sbv; lo = sq[W-1:0]; hi = sr[W-1:0]; end
      3'd3: if (b == '0) dz = 1'b1;
            else begin uq = ua / ub; ur = ua % ub; lo = uq[W-1:0]; hi = ur[W-1:0]; end
      3'd4: hi = a;
      3'd5: lo = a;
      default: ;
    endcase
  endfunction

  task automatic idleBus();
    bus.start = 1'b0; bus.op = 3'd6; bus.a = '0; bus.b = '0; bus.annul = 1'b0;
  endtask

  task automatic drive(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic an);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.annul = an;
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic an);
    int   n;
    int   lat;
    logic accept;
    logic is_div;
    logic multi;
    logic [W-1:0] h;
    logic [W-1:0] l;
    logic d;
    exp_t e;
    while (cyc < free_cyc) @(negedge clk);
    drive(op, a, b, an);
    n = cyc;
    is_div = (op == 3'd2) || (op == 3'd3);
    accept = !an && (op < 3'd6);
    multi  = accept && ((is_div && b != '0) || (ITER_MUL && op < 3'd2));
    #1 checkOutput("stall", bus.stall, multi);
    lat = multi ? W + 2 : 1;
    if (accept) begin
      h = model_hi; l = model_lo;
      refModel(op, a, b, h, l, d);
      model_hi = h; model_lo = l;
      e.hi = h; e.lo = l; e.dz = d; e.cyc = n + lat;
      scoreboard.push_back(e);
    end
    free_cyc = n + lat;
    @(negedge clk);
    idleBus();
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 100 && scoreboard.size() != 0; i++) @(negedge clk);
    if (scoreboard.size() != 0) begin
      checkOutput("drain_timeout", scoreboard.size(), 0);
      scoreboard.delete();
    end
  endtask

  task automatic annulMidRun();
    int n;
    while (cyc < free_cyc) @(negedge clk);
    drive(3'd3, 100, 7, 1'b0);
    n = cyc;
    @(negedge clk);
    idleBus();
    while (cyc < n + 5) @(negedge clk);
    checkOutput("busy_in_run", bus.busy, 1);
    checkOutput("stall_in_run", bus.stall, 1);
    while (cyc < n + 10) @(negedge clk);
    bus.annul = 1'b1;
    @(negedge clk);
    bus.annul = 1'b0;
    checkOutput("busy_after_annul", bus.busy, 0);
    checkOutput("hi_after_annul", bus.hi, model_hi);
    checkOutput("lo_after_annul", bus.lo, model_lo);
    free_cyc = cyc;
    applyStimulus(3'd3, 100, 7, 1'b0);
  endtask

  task automatic resetMidDiv();
    waitDrain();
    while (cyc < free_cyc) @(negedge clk);
    drive(3'd2, 1000, 3, 1'b0);
    @(negedge clk);
    idleBus();
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_hi", bus.hi, 0);
    checkOutput("rst_lo", bus.lo, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_div_zero", bus.div_zero, 0);
    rst = 1'b0;
    model_hi = '0;
    model_lo = '0;
    free_cyc = cyc;
  endtask

  task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int n, sa, sbv, q, r;
    if (op == 3'd2) begin sa = int'($signed(a)); sbv = int'($signed(b)); end
    else begin sa = int'(a); sbv = int'(b); end
    q = sa / sbv;
    r = sa % sbv;
    bus8.start = 1'b1; bus8.op = op; bus8.a = a; bus8.b = b;
    n = cyc;
    @(negedge clk);
    bus8.start = 1'b0;
    while (cyc < n + 9) @(negedge clk);
    checkOutput("w8_busy", bus8.busy, 1);
    checkOutput("w8_no_early_done", bus8.done, 0);
    @(negedge clk);
    checkOutput("w8_done", bus8.done, 1);
    checkOutput("w8_lo", bus8.lo, q[7:0]);
    checkOutput("w8_hi", bus8.hi, r[7:0]);
    @(negedge clk);
    checkOutput("w8_done_pulse", bus8.done, 0);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation, on time.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (bus.done) begin
        if (scoreboard.size() == 0) begin
          checkOutput("spurious_done", 1, 0);
        end else begin
          mon_e = scoreboard.pop_front();
          checkOutput("done_cycle", cyc, mon_e.cyc);
          checkOutput("hi", bus.hi, mon_e.hi);
          checkOutput("lo", bus.lo, mon_e.lo);
          checkOutput("div_zero", bus.div_zero, mon_e.dz);
        end
      end else if (bus.div_zero) begin
        checkOutput("stray_div_zero", 1, 0);
      end else if (scoreboard.size() != 0 && cyc > scoreboard[0].cyc) begin
        checkOutput("missing_done", 0, 1);
        void'(scoreboard.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got cycle %0d, expected end well before", cyc);
    $fatal(1);
  end

  initial begin
    idleBus();
    bus8.start = 1'b0; bus8.op = 3'd6; bus8.a = '0; bus8.b = '0; bus8.annul = 1'b0;
    model_hi = '0;
    model_lo = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_hi", bus.hi, 0);
    checkOutput("reset_lo", bus.lo, 0);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_done", bus.done, 0);
    checkOutput("reset_div_zero", bus.div_zero, 0);
    checkOutput("reset_stall", bus.stall, 0);
    rst = 1'b0;
    free_cyc = cyc;

    applyStimulus(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    applyStimulus(3'd3, 32'hFFFF_FFFF, 32'h10, 1'b0);
    applyStimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(3'd4, 32'h1234, 32'd0, 1'b0);
    applyStimulus(3'd5, 32'h5678, 32'd0, 1'b0);
    applyStimulus(3'd2, 32'd99, 32'd0, 1'b0);
    annulMidRun();
    applyStimulus(3'd0, 32'hFFFF_FFFD, 32'd5, 1'b0);
    applyStimulus(3'd4, 32'hA5A5_A5A5, 32'd0, 1'b0);
    applyStimulus(3'd5, 32'h5A5A_5A5A, 32'd0, 1'b0);
    applyStimulus(3'd6, 32'hDEAD_BEEF, 32'd1, 1'b0);
    applyStimulus(3'd4, 32'hDEAD_BEEF, 32'd1, 1'b1);
    applyStimulus(3'd2, 32'hDEAD_BEEF, 32'd3, 1'b1);

    run8(3'd3, 8'd200, 8'd9);
    run8(3'd2, 8'h80, 8'hFF);
    run8(3'd2, 8'h9C, 8'd7);

    resetMidDiv();

    for (int i = 0; i < 60; i++) begin
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         an;
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = '1;
        2:       b = W'($urandom_range(1, 255));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 15) == 0) a = 32'h8000_0000;
      an = ($urandom_range(0, 9) == 0);
      applyStimulus(op, a, b, an);
    end

    waitDrain();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multiply/divide unit that owns the HI/LO register pair. It sits in the execute stage beside the ALU and replaces the ALU-embedded multiply and external-divider handshake with one block. It provides a start/stall/done handshake, an iterative signed/unsigned divider and annul-on-exception. It also has an optional iterative multiplier.

## Interface
Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; must be ≥ 4.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request valid this cycle; sampled only in IDLE
- op  in  3  operation code (MD_OP_* from defines.vh)
- a  in  WIDTH  operand rs (dividend / multiplicand / MTHI-MTLO data)
- b  in  WIDTH  operand rt (divisor / multiplier)
- annul  in  1  cancel the in-flight or requested operation (exception flush)
- stall  out  1  combinational; pipeline must hold execute stage
- busy  out  1  registered; multi-cycle operation in flight
- done  out  1  registered one-cycle pulse; hi/lo hold the new result
- div_zero  out  1  registered one-cycle pulse with done; divide with b == 0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation
- The op codes are MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5, and NOP=6/7. A NOP has no effect.
- The FSM has the states IDLE, RUN and FIX.
  - IDLE → RUN on start & !annul with op DIV/DIVU (or MULT/MULTU when the macro is set) and b != 0 for divides.
  - RUN → FIX after WIDTH iterations. The iteration counter runs 0..WIDTH-1.
  - FIX → IDLE.
  - RUN/FIX → IDLE on annul.
- Single-cycle ops are accepted in IDLE and write on the same edge:
  - MTHI: hi←a.
  - MTLO: lo←a.
  - MULT/MULTU without the macro: {hi,lo}←a×b, with a 2·WIDTH product, signed for MULT.
- Divide:
  - The operation is a restoring radix-2 divide on magnitudes, one quotient bit per cycle.
  - FIX applies the signs. The quotient truncates toward zero. The remainder takes the sign of the dividend.
  - FIX then writes lo←quotient and hi←remainder.
  - For DIV with a = MIN and b = -1, the result is lo = MIN and hi = 0, with no flag.
- Divide by zero: there is no RUN phase and hi/lo are unchanged. done and div_zero pulse on the following cycle.
- start while busy is ignored. The pipeline guarantees this via stall.
- annul:
  - In IDLE, annul suppresses start.
  - In RUN/FIX, annul aborts the operation: hi/lo are not written and done is not raised.
- A result is never partially written. hi and lo are both written in the same FIX edge.

## Timing
- Reset values: state=IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, and the counter and working registers are 0.
- Multi-cycle operation accepted in cycle T:
  - busy=1 in cycles T+1 … T+WIDTH+1.
  - hi/lo are updated and done=1 in cycle T+WIDTH+2.
  - The total latency is WIDTH+2 cycles.
- stall = busy | (start & !annul & IDLE & op is multi-cycle & !(divide with b==0)). It is low in the done cycle, which allows back-to-back issue at T+WIDTH+2.
- Single-cycle ops: hi/lo are visible in T+1, done=1 in T+1, and stall stays 0.
- Divide by zero: done=div_zero=1 in T+1, and stall stays 0.
- annul in cycle X during RUN/FIX: the FSM is in IDLE with busy=0 in X+1, and done does not fire.
- rst has priority over annul and start on every edge.

## Configuration
- MULDIV_ITER_MUL_EN defined:
  - MULT/MULTU use a shift-add multiplier on magnitudes through the same RUN/FIX path.
  - FIX negates the product when a[WIDTH-1]^b[WIDTH-1] is set for MULT.
  - The latency is WIDTH+2 cycles, the same as divide, and no hardware multiplier is inferred.
- MULDIV_ITER_MUL_EN undefined:
  - MULT/MULTU are single-cycle and use a combinational multiplier.
  - They never raise stall.

## Structure
- The MD_OP_* codes and the FSM state encodings go in the shared defines.vh, next to the ALUOP_* codes.
- There is one sub-module, muldiv_iter_core. It is the WIDTH-parametrised shift/subtract datapath and iteration counter, and serves both divide and iterative multiply.
- muldiv_unit owns the FSM, the sign fix-up, the HI/LO registers and the handshake.

## Test plan
WIDTH=32 unless noted.
1. DIV, a=-7, b=2 → done at T+34 with lo=0xFFFFFFFD (-3) and hi=0xFFFFFFFF (-1); stall=1 in T..T+33.
2. DIVU, a=0xFFFFFFFF, b=0x10 → lo=0x0FFFFFFF, hi=0xF. Then DIV, a=0x80000000, b=-1 → lo=0x80000000, hi=0.
3. DIV with b=0, hi=0x1234/lo=0x5678 beforehand → done=div_zero=1 at T+1, hi/lo unchanged, stall never asserted.
4. DIVU 100/7 started, then annul at T+10 → busy=0 at T+11, no done, hi/lo unchanged. A new DIVU issued at T+11 completes normally.
5. MULT, a=-3, b=5 → {hi,lo}=0xFFFFFFFF_FFFFFFF1. Without the macro this appears at T+1 with no stall; with MULDIV_ITER_MUL_EN it appears at T+34.
6. MTHI 0xA5A5A5A5, then MTLO 0x5A5A5A5A on consecutive cycles → hi/lo match in the next cycles. rst asserted mid-DIV → all outputs 0 on the next cycle. Repeat with WIDTH=8: DIVU 200/9 → lo=22, hi=2 at T+10.
